// File: rtl/bnbp_pkg.sv
// bnbp_pkg: shared state type, order encodings and frame-length helper for bit_pair_serializer.
package bnbp_pkg;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    localparam logic ORDER_MSB_FIRST = 1'b0;
    localparam logic ORDER_LSB_FIRST = 1'b1;

    function automatic int frame_len(input int width, input bit parity);
        return parity ? width + 1 : width;
    endfunction

endpackage

// File: rtl/bnbp_bit_reverse.sv
// bnbp_bit_reverse: combinational WIDTH-bit reverser used when loading an LSB-first word.
module bnbp_bit_reverse #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign q_o[i] = d_i[WIDTH-1-i];
    end

endmodule

// File: rtl/bit_pair_serializer.sv
// bit_pair_serializer: valid/ready word in, one bit per clock out, MSB- or LSB-first per word.
// Define BNBP_PARITY_EN to append an even-parity bit to every frame.
module bit_pair_serializer
    import bnbp_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             order,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy
);

`ifdef BNBP_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FL = frame_len(WIDTH, PAR_EN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FL - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FL-1:0]    sr_q, sr_d, load;
    logic             last_q, last_d;
    logic [WIDTH-1:0] rev, ordered;
    logic             at_last, accept;

    bnbp_bit_reverse #(.WIDTH(WIDTH)) u_rev (.d_i(in_data), .q_o(rev));

    assign ordered = (order == ORDER_LSB_FIRST) ? rev : in_data;

    // The frame head sits at the MSB of the shift register; parity trails the data.
`ifdef BNBP_PARITY_EN
    assign load = {ordered, ^in_data};
`else
    assign load = ordered;
`endif

    assign at_last  = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    assign in_ready = !reset && ((state_q == IDLE) || at_last);
    assign accept   = in_ready && in_valid;

    always_comb begin
        state_d = accept ? SHIFT : at_last ? IDLE : state_q;
        cnt_d   = accept ? '0 : (state_q == SHIFT && !at_last) ? cnt_q + 1'b1 : cnt_q;
        sr_d    = accept ? load : (state_d == SHIFT) ? {sr_q[FL-2:0], 1'b0} : '0;
        last_d  = (state_d == SHIFT) && (cnt_d == LAST_CNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            last_q  <= last_d;
        end
    end

    assign out_bit   = sr_q[FL-1];
    assign out_valid = (state_q == SHIFT);
    assign busy      = (state_q == SHIFT);
    assign out_last  = last_q;

endmodule

// File: tb/tb_bit_pair_serializer.sv
// tb_bit_pair_serializer: table vectors and corner sequences checked through an expected-bit scoreboard.
module tb_bit_pair_serializer;
    import bnbp_pkg::*;

`ifdef BNBP_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FL2 = 2 + int'(PAR);
    localparam int FL4 = 4 + int'(PAR);

    logic clk = 1'b0;
    logic reset;
    logic in_valid, order, in_ready, out_bit, out_valid, out_last, busy;
    logic [1:0] in_data;
    logic v4, o4, r4, b4, ov4, ol4, bz4;
    logic [3:0] d4;

    int checks = 0;
    int errors = 0;

    typedef struct packed {logic b; logic l;} exp_t;
    typedef struct {logic [1:0] d; logic o; logic [1:0] e;} vec_t;

    exp_t sbq[$];
    exp_t e;
    vec_t vecs[7];
    int   run = 0;
    int   max_run = 0;
    bit   mon_on = 1'b0;
    logic [4:0] seq4 = 5'b00011;

    always #5 clk = ~clk;

    bit_pair_serializer #(.WIDTH(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .order(order),
        .in_ready(in_ready), .out_bit(out_bit), .out_valid(out_valid), .out_last(out_last), .busy(busy)
    );

    bit_pair_serializer #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(v4), .in_data(d4), .order(o4),
        .in_ready(r4), .out_bit(b4), .out_valid(ov4), .out_last(ol4), .busy(bz4)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, req, $time);
        end
    endfunction

    // e holds the data bits in emission order, first bit in e[1].
    function automatic void push_exp(input logic [1:0] ev);
        sbq.push_back('{b: ev[1], l: 1'b0});
        sbq.push_back('{b: ev[0], l: !PAR});
        if (PAR) sbq.push_back('{b: ^ev, l: 1'b1});
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            if (out_valid === 1'b1) begin
                run++;
                if (run > max_run) max_run = run;
                check("sb_nonempty", sbq.size() != 0, 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("out_bit", out_bit, e.b);
                    check("out_last", out_last, e.l);
                end
            end else begin
                run = 0;
                check("idle_out", {out_bit, out_last, busy}, 3'b000);
            end
        end
    end

    task automatic send(input logic [1:0] d, input logic o, input logic [1:0] ev);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        order    = o;
        while (!in_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", n < 16, 1);
        push_exp(ev);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_wait();
        repeat (FL2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{d: 2'b10, o: ORDER_MSB_FIRST, e: 2'b10};
        vecs[1] = '{d: 2'b10, o: ORDER_LSB_FIRST, e: 2'b01};
        vecs[2] = '{d: 2'b01, o: ORDER_MSB_FIRST, e: 2'b01};
        vecs[3] = '{d: 2'b11, o: ORDER_LSB_FIRST, e: 2'b11};
        vecs[4] = '{d: 2'b00, o: ORDER_MSB_FIRST, e: 2'b00};
        vecs[5] = '{d: 2'b01, o: ORDER_LSB_FIRST, e: 2'b10};
        vecs[6] = '{d: 2'b11, o: ORDER_MSB_FIRST, e: 2'b11};
        reset = 1'b1; in_valid = 1'b0; in_data = '0; order = 1'b0;
        v4 = 1'b0; d4 = '0; o4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", {out_bit, out_valid, out_last, busy}, 4'b0000);
        check("rst_ready", in_ready, 0);
        check("rst_ready4", r4, 0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", in_ready, 1);
        mon_on = 1'b1;

        send(2'b10, ORDER_MSB_FIRST, 2'b10);
        idle_wait();
        check("valid_drop", out_valid, 0);

        max_run = 0;
        send(2'b10, ORDER_LSB_FIRST, 2'b01);
        send(2'b01, ORDER_MSB_FIRST, 2'b01);
        idle_wait();
        check("b2b_run", max_run, 2 * FL2);

        send(2'b10, ORDER_MSB_FIRST, 2'b10);
        in_valid = 1'b1;
        for (int i = 0; i < FL2 - 1; i++) begin
            in_data = (i % 2 == 0) ? 2'b11 : 2'b00;
            order   = ORDER_LSB_FIRST;
            check("ready_midframe", in_ready, 0);
            @(posedge clk);
            #1;
        end
        in_data = 2'b00;
        order   = ORDER_MSB_FIRST;
        check("ready_lastbit", in_ready, 1);
        push_exp(2'b00);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        idle_wait();

        max_run = 0;
        for (int i = 0; i < 7; i++) send(vecs[i].d, vecs[i].o, vecs[i].e);
        idle_wait();
        check("table_run", max_run, 7 * FL2);

        send(2'b11, ORDER_MSB_FIRST, 2'b11);
        reset = 1'b1;
        #1;
        check("ready_in_reset", in_ready, 0);
        @(posedge clk);
        #1;
        check("abort_out", {out_valid, busy, out_last}, 3'b000);
        sbq.delete();
        reset = 1'b0;
        #1;
        check("ready_post_abort", in_ready, 1);
        repeat (3) @(posedge clk);
        #1;

        v4 = 1'b1; d4 = 4'b1000; o4 = ORDER_LSB_FIRST;
        @(posedge clk);
        #1;
        d4 = 4'b1111; o4 = ORDER_MSB_FIRST;
        for (int i = 0; i < FL4; i++) begin
            check("w4_valid", ov4, 1);
            check("w4_bit", b4, seq4[4-i]);
            check("w4_last", ol4, i == FL4 - 1);
            check("w4_ready", r4, i == FL4 - 1);
            if (i == FL4 - 1) v4 = 1'b0;
            @(posedge clk);
            #1;
        end
        check("w4_idle", {ov4, bz4}, 2'b00);

        for (int n = 0; n < 20 && sbq.size() != 0; n++) @(posedge clk);
        #1;
        check("sb_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
